// File: rtl/peg_bmtx_mul_arbiter.sv
// peg_bmtx_mul_arbiter
// Round-robin arbiter that time-shares one pipelined signed x unsigned
// multiplier among NUM_REQ requesters. Each granted op is tagged with its
// owner; the tag travels down a shadow pipe that advances in lockstep with the
// multiplier (both gated by mul_ce), so the tag at the head always names the
// owner of the product currently on mul_dout.
//
// Handshake semantics (both request and response sides): a transfer happens on
// a rising clock edge where valid and ready are both 1. The producer holds
// valid and data stable until that edge; ready may rise and fall freely and is
// never used to decide whether to raise valid. Here req_ready is one-hot (or
// zero) and computed combinationally from req_valid, rsp_ready and internal
// state; it never depends on itself.
//
// Backpressure: when the head op's owner is not ready, mul_ce drops. That
// freezes the multiplier and the tag pipe together, so mul_dout stays valid
// and no in-flight result can be overwritten. No new op is granted while
// frozen, because there is no free slot to load it into.

module peg_bmtx_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int A_W        = 16,
  parameter int B_W        = 14,
  parameter int P_W        = 30,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 32,
  localparam int TAG_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int INF_W     = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [P_W-1:0]         rsp_p,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
  input  logic [P_W-1:0]         mul_dout,
  output logic [INF_W-1:0]       inflight,
  output logic                   idle,
  output logic [CNT_W-1:0]       issued_cnt
);

  // Tag pipe: one {vld, tag} entry per multiplier stage; index PIPE_DEPTH-1 is the head.
  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]      tag_q [PIPE_DEPTH];
  logic [TAG_W-1:0]      tag_d [PIPE_DEPTH];

  // Round-robin pointer holds the last granted requester; search starts just after it.
  logic [TAG_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [INF_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]      issued_cnt_q, issued_cnt_d;

  logic                  head_vld;
  logic [TAG_W-1:0]      head_tag;
  logic                  rsp_xfer;
  logic                  grant_any;
  logic [TAG_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    grant_vec;

  assign head_vld = vld_q[PIPE_DEPTH-1];
  assign head_tag = tag_q[PIPE_DEPTH-1];

  // Freeze the whole pipe only when the head result has nowhere to go.
  assign mul_ce   = ~(head_vld & ~rsp_ready[head_tag]);

  // A response leaves on any edge where the head owner accepts it.
  assign rsp_xfer = head_vld & rsp_ready[head_tag];

  // Route the head result to its owner; the product bus itself is shared.
  always_comb begin
    rsp_valid = '0;
    if (head_vld) begin
      rsp_valid[head_tag] = 1'b1;
    end
  end

  assign rsp_p = mul_dout;

  // Round-robin search starting after rr_ptr. Reset gates it so nothing is
  // granted (and no operand is driven) while the block is held in reset.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (mul_ce && enable && ap_rst_n) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= NUM_REQ) begin
          cand = cand - NUM_REQ;
        end
        if (!grant_any && req_valid[TAG_W'(cand)]) begin
          grant_any = 1'b1;
          grant_idx = TAG_W'(cand);
        end
      end
    end
  end

  // One-hot accept back to the winner.
  always_comb begin
    grant_vec = '0;
    if (grant_any) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant_vec;

  // Operand mux: winner's operands, zero when nothing is granted.
  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vec[i]) begin
        mul_din0 = req_a[i*A_W +: A_W];
        mul_din1 = req_b[i*B_W +: B_W];
      end
    end
  end

  // Tag pipe shifts only with mul_ce, mirroring the multiplier's own stages.
  always_comb begin
    vld_d = vld_q;
    for (int s = 0; s < PIPE_DEPTH; s++) begin
      tag_d[s] = tag_q[s];
    end
    if (mul_ce) begin
      vld_d[0] = grant_any;
      tag_d[0] = grant_idx;
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        vld_d[s] = vld_q[s-1];
        tag_d[s] = tag_q[s-1];
      end
    end
  end

  // Pointer moves to the winner; it holds when nothing is granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = grant_idx;
    end
  end

  // In-flight count: grant adds, delivered response removes, both cancel out.
  always_comb begin
    inflight_d = inflight_q;
    case ({grant_any, rsp_xfer})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Free-running issued-op counter, wraps naturally.
  always_comb begin
    issued_cnt_d = issued_cnt_q + CNT_W'(grant_any);
  end

  // State registers; reset discards every in-flight op.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q        <= '0;
      for (int s = 0; s < PIPE_DEPTH; s++) begin
        tag_q[s] <= '0;
      end
      rr_ptr_q     <= TAG_W'(NUM_REQ - 1);
      inflight_q   <= '0;
      issued_cnt_q <= '0;
    end else begin
      vld_q        <= vld_d;
      for (int s = 0; s < PIPE_DEPTH; s++) begin
        tag_q[s] <= tag_d[s];
      end
      rr_ptr_q     <= rr_ptr_d;
      inflight_q   <= inflight_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign inflight   = inflight_q;
  assign issued_cnt = issued_cnt_q;
  assign idle       = (inflight_q == '0) & ~grant_any;

endmodule

// File: tb/tb_peg_bmtx_mul_arbiter.sv
// Bench for peg_bmtx_mul_arbiter: a cycle table for grant order, routing,
// latency and counters, then hand sequences for stall, drain and reset.

module tb_peg_bmtx_mul_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int A_W        = 16;
  localparam int B_W        = 14;
  localparam int P_W        = 30;
  localparam int PIPE_DEPTH = 3;
  localparam int CNT_W      = 32;
  localparam int TAG_W      = 2;
  localparam int INF_W      = 2;

  // Hand-computed products for the fixed per-requester operands below.
  localparam logic [P_W-1:0] P0 = P_W'(-15);         // -3 * 5
  localparam logic [P_W-1:0] P1 = P_W'(-536838144);  // -32768 * 16383
  localparam logic [P_W-1:0] P2 = P_W'(536821761);   // 32767 * 16383
  localparam logic [P_W-1:0] P3 = P_W'(700);         // 100 * 7

  // ---------------- clock / reset ----------------
  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  logic                   enable;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [P_W-1:0]         rsp_p;
  logic                   mul_ce;
  logic [A_W-1:0]         mul_din0;
  logic [B_W-1:0]         mul_din1;
  logic [P_W-1:0]         mul_dout;
  logic [INF_W-1:0]       inflight;
  logic                   idle;
  logic [CNT_W-1:0]       issued_cnt;

  peg_bmtx_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W),
    .PIPE_DEPTH(PIPE_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .inflight(inflight), .idle(idle), .issued_cnt(issued_cnt)
  );

  // Shared multiplier model: 3 ce-enabled stages, signed a times unsigned b.
  logic signed [P_W-1:0] m_q [PIPE_DEPTH];
  always @(posedge ap_clk) begin
    if (mul_ce) begin
      m_q[0] <= $signed(mul_din0) * $signed({1'b0, mul_din1});
      for (int s = 1; s < PIPE_DEPTH; s++) m_q[s] <= m_q[s-1];
    end
  end
  assign mul_dout = m_q[PIPE_DEPTH-1];

  // ---------------- operands ----------------
  logic signed [A_W-1:0] op_a [NUM_REQ];
  logic [B_W-1:0]        op_b [NUM_REQ];
  logic [P_W-1:0]        op_p [NUM_REQ];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [TAG_W+P_W-1:0] exp_q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Pop/compare on response transfer, then push expected result for a new grant.
  task automatic sb_step(input string nm);
    logic [TAG_W+P_W-1:0] e;
    logic [NUM_REQ-1:0]   oh;
    if ((rsp_valid & rsp_ready) != '0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s unexpected_rsp: got rsp_valid=%b, required none", nm, rsp_valid);
      end else begin
        e  = exp_q.pop_front();
        oh = '0;
        oh[e[TAG_W+P_W-1:P_W]] = 1'b1;
        check({nm, " rsp_valid"}, 64'(rsp_valid), 64'(oh));
        check({nm, " rsp_p"}, 64'(rsp_p), 64'(e[P_W-1:0]));
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[TAG_W'(i)]) exp_q.push_back({TAG_W'(i), op_p[i]});
    end
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic               en;
    logic [NUM_REQ-1:0] rv;
    logic [NUM_REQ-1:0] rr;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] rspv;
    logic [P_W-1:0]     p;
    int                 infl;
    logic               idl;
    int                 issued;
    logic               ce;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic en, logic [3:0] rv, logic [3:0] rr, logic [3:0] ready,
                              logic [3:0] rspv, logic [P_W-1:0] p, int infl, logic idl,
                              int issued, logic ce);
    vec_t v;
    v.en = en; v.rv = rv; v.rr = rr; v.ready = ready; v.rspv = rspv; v.p = p;
    v.infl = infl; v.idl = idl; v.issued = issued; v.ce = ce;
    return v;
  endfunction

  task automatic drive(input logic en, input logic [3:0] rv, input logic [3:0] rr);
    @(negedge ap_clk);
    enable = en; req_valid = rv; rsp_ready = rr;
    #2;
  endtask

  initial begin
    logic [A_W-1:0] ed0;
    logic [B_W-1:0] ed1;

    op_a[0] = -16'sd3;     op_b[0] = 14'd5;     op_p[0] = P0;
    op_a[1] = -16'sd32768; op_b[1] = 14'd16383; op_p[1] = P1;
    op_a[2] = 16'sd32767;  op_b[2] = 14'd16383; op_p[2] = P2;
    op_a[3] = 16'sd100;    op_b[3] = 14'd7;     op_p[3] = P3;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*A_W +: A_W] = op_a[i];
      req_b[i*B_W +: B_W] = op_b[i];
    end

    //            en rv    rr    ready rspv  p   infl idle iss ce
    // all four requesters held valid: order 0,1,2,3,0,1,2,3
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'h1, 4'h0, '0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'h2, 4'h0, '0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'h4, 4'h0, '0, 2, 0, 2, 1));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'h8, 4'h1, P0, 3, 0, 3, 1));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'h1, 4'h2, P1, 3, 0, 4, 1));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'h2, 4'h4, P2, 3, 0, 5, 1));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'h4, 4'h8, P3, 3, 0, 6, 1));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'h8, 4'h1, P0, 3, 0, 7, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h2, P1, 3, 0, 8, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h4, P2, 2, 0, 8, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h8, P3, 1, 0, 8, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h0, '0, 0, 1, 8, 1));
    // single req0 op: response exactly 3 cycles after grant
    tbl.push_back(mk(1, 4'h1, 4'hF, 4'h1, 4'h0, '0, 0, 0, 8, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h0, '0, 1, 0, 9, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h0, '0, 1, 0, 9, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h1, P0, 1, 0, 9, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h0, '0, 0, 1, 9, 1));
    // sparse requests: pointer 0 -> skips 1, grants 2; then wraps past 3 to 0
    tbl.push_back(mk(1, 4'h5, 4'hF, 4'h4, 4'h0, '0, 0, 0, 9, 1));
    tbl.push_back(mk(1, 4'h5, 4'hF, 4'h1, 4'h0, '0, 1, 0, 10, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h0, '0, 2, 0, 11, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h4, P2, 2, 0, 11, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h1, P0, 1, 0, 11, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h0, '0, 0, 1, 11, 1));
    // enable low blocks grants
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h0, '0, 0, 1, 11, 1));

    // ---------------- reset state ----------------
    ap_rst_n = 1'b0; enable = 1'b1; req_valid = 4'hF; rsp_ready = 4'hF;
    repeat (2) @(negedge ap_clk);
    #2;
    check("rst req_ready", 64'(req_ready), 64'h0);
    check("rst rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst idle", 64'(idle), 64'h1);
    check("rst mul_ce", 64'(mul_ce), 64'h1);
    check("rst din0", 64'(mul_din0), 64'h0);
    check("rst din1", 64'(mul_din1), 64'h0);
    check("rst inflight", 64'(inflight), 64'h0);
    check("rst issued", 64'(issued_cnt), 64'h0);
    @(negedge ap_clk);
    req_valid = 4'h0;
    ap_rst_n  = 1'b1;

    // ---------------- table ----------------
    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].en, tbl[r].rv, tbl[r].rr);
      ed0 = '0; ed1 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tbl[r].ready[TAG_W'(i)]) begin ed0 = op_a[i]; ed1 = op_b[i]; end
      end
      check($sformatf("row%0d req_ready", r), 64'(req_ready), 64'(tbl[r].ready));
      check($sformatf("row%0d rsp_valid", r), 64'(rsp_valid), 64'(tbl[r].rspv));
      if (tbl[r].rspv != '0)
        check($sformatf("row%0d rsp_p", r), 64'(rsp_p), 64'(tbl[r].p));
      check($sformatf("row%0d inflight", r), 64'(inflight), 64'(tbl[r].infl));
      check($sformatf("row%0d idle", r), 64'(idle), 64'(tbl[r].idl));
      check($sformatf("row%0d issued", r), 64'(issued_cnt), 64'(tbl[r].issued));
      check($sformatf("row%0d mul_ce", r), 64'(mul_ce), 64'(tbl[r].ce));
      check($sformatf("row%0d din0", r), 64'(mul_din0), 64'(ed0));
      check($sformatf("row%0d din1", r), 64'(mul_din1), 64'(ed1));
    end

    // ---------------- stall: requester 1 refuses its result for 5 cycles ----------------
    for (int c = 0; c < 3; c++) begin
      drive(1, 4'hF, 4'hD);
      check($sformatf("stall fill%0d req_ready", c), 64'(req_ready), 64'(4'h2 << c));
      sb_step("stall fill");
    end
    for (int c = 0; c < 5; c++) begin
      drive(1, 4'hF, 4'hD);
      check($sformatf("stall%0d mul_ce", c), 64'(mul_ce), 64'h0);
      check($sformatf("stall%0d req_ready", c), 64'(req_ready), 64'h0);
      check($sformatf("stall%0d rsp_valid", c), 64'(rsp_valid), 64'h2);
      check($sformatf("stall%0d rsp_p", c), 64'(rsp_p), 64'(P1));
      sb_step("stall hold");
    end
    drive(1, 4'hF, 4'hF);
    check("stall release mul_ce", 64'(mul_ce), 64'h1);
    check("stall release req_ready", 64'(req_ready), 64'h1);
    sb_step("stall release");
    for (int c = 0; c < 6; c++) begin
      drive(1, 4'h0, 4'hF);
      sb_step("stall drain");
    end
    check("stall queue empty", 64'(exp_q.size()), 64'h0);
    check("stall idle", 64'(idle), 64'h1);

    // ---------------- enable low with 3 ops in flight ----------------
    for (int c = 0; c < 3; c++) begin
      drive(1, 4'hF, 4'hF);
      check($sformatf("drain fill%0d req_ready", c), 64'(req_ready), 64'(4'h2 << c));
      sb_step("drain fill");
    end
    for (int c = 0; c < 6; c++) begin
      drive(0, 4'hF, 4'hF);
      check($sformatf("drain%0d req_ready", c), 64'(req_ready), 64'h0);
      sb_step("drain");
    end
    check("drain queue empty", 64'(exp_q.size()), 64'h0);
    check("drain idle", 64'(idle), 64'h1);
    check("drain inflight", 64'(inflight), 64'h0);

    // ---------------- reset with 3 ops in flight ----------------
    for (int c = 0; c < 3; c++) begin
      drive(1, 4'h2, 4'hF);
      sb_step("rstmid fill");
    end
    drive(1, 4'h0, 4'hF);
    check("rstmid pre inflight", 64'(inflight), 64'h3);
    check("rstmid pre rsp_valid", 64'(rsp_valid), 64'h2);
    ap_rst_n = 1'b0;
    #1;
    check("rstmid rsp_valid", 64'(rsp_valid), 64'h0);
    check("rstmid inflight", 64'(inflight), 64'h0);
    check("rstmid idle", 64'(idle), 64'h1);
    check("rstmid issued", 64'(issued_cnt), 64'h0);
    exp_q.delete();
    @(negedge ap_clk);
    req_valid = 4'hF; rsp_ready = 4'hF; enable = 1'b1;
    ap_rst_n = 1'b1;
    #2;
    check("rstmid first grant", 64'(req_ready), 64'h1);
    sb_step("rstmid after");
    for (int c = 0; c < 5; c++) begin
      drive(1, 4'h0, 4'hF);
      sb_step("rstmid drain");
    end
    check("rstmid queue empty", 64'(exp_q.size()), 64'h0);
    check("rstmid idle", 64'(idle), 64'h1);
    check("rstmid issued end", 64'(issued_cnt), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
